// File: rtl/gf_pkg.sv
// Shared types and helpers for the GF(2^N) power-map engine.
package gf_pkg;

    // Engine control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default irreducible polynomials for common field widths.
    localparam logic [4:0] POLY_N4 = 5'h13;   // x^4+x+1
    localparam logic [6:0] POLY_N6 = 7'h43;   // x^6+x+1
    localparam logic [8:0] POLY_N8 = 9'h11B;  // x^8+x^4+x^3+x+1

    // Reduce a carry-less product (up to 31 bits, i.e. 2N-1 for N<=16)
    // modulo poly (bit n set). Bits at and above n are cleared MSB first,
    // leaving the field element in the low n bits of the result.
    function automatic logic [15:0] gf_reduce(
        input logic [30:0] prod,
        input logic [16:0] poly,
        input int          n
    );
        logic [30:0] r;
        r = prod;
        for (int i = 30; i >= 2; i--) begin
            if ((i >= n) && r[i]) begin
                r = r ^ ({14'd0, poly} << (i - n));
            end else begin
                r = r;
            end
        end
        return r[15:0];
    endfunction

endpackage

// File: rtl/gf_mul.sv
// Combinational N-bit polynomial-basis multiplier over GF(2^N).
module gf_mul
    import gf_pkg::*;
#(
    parameter int         N    = 6,
    parameter logic [N:0] POLY = POLY_N6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p
);

    localparam logic [16:0] POLY_EXT = 17'(POLY);

    logic [30:0] clmul_s;

    // Carry-less shift-and-xor product followed by modular reduction.
    always_comb begin
        clmul_s = 31'd0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) begin
                clmul_s = clmul_s ^ (31'(a) << i);
            end else begin
                clmul_s = clmul_s;
            end
        end
        p = N'(gf_reduce(clmul_s, POLY_EXT, N));
    end

endmodule

// File: rtl/gf_pow_engine.sv
// Sequential constant-time x^e engine in GF(2^N), MSB-first square-and-multiply.
// Every operand spends N iteration cycles plus one settle cycle in RUN,
// whatever the value of x or e.
module gf_pow_engine
    import gf_pkg::*;
#(
    parameter int         N    = 6,
    parameter logic [N:0] POLY = POLY_N6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    input  logic [N-1:0] in_e,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y,
    output logic         busy
);

    // k carries one extra MSB: it is set once bit 0 has been processed,
    // which marks the final RUN cycle where the result is published.
    localparam int          KW     = $clog2(N);
    localparam logic [KW:0] K_INIT = (KW + 1)'(N - 1);
    localparam logic [KW:0] K_ONE  = (KW + 1)'(1);
    localparam logic [N-1:0] ONE   = {{(N - 1){1'b0}}, 1'b1};

    state_t       state_r;
    state_t       state_nx_s;
    logic [N-1:0] x_q_r;
    logic [N-1:0] e_q_r;
    logic [N-1:0] acc_r;
    logic [N-1:0] out_y_r;
    logic [KW:0]  k_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         busy_r;
    logic [N-1:0] sq_s;
    logic [N-1:0] sqx_s;
    logic [N-1:0] acc_nx_s;
    logic         bits_done_s;

    assign bits_done_s = k_r[KW];

    gf_mul #(.N(N), .POLY(POLY)) u_square (
        .a (acc_r),
        .b (acc_r),
        .p (sq_s)
    );

    gf_mul #(.N(N), .POLY(POLY)) u_mul_x (
        .a (sq_s),
        .b (x_q_r),
        .p (sqx_s)
    );

    // Select square or square-times-x depending on the current exponent bit.
    always_comb begin
        acc_nx_s = sq_s;
        if (e_q_r[k_r[KW-1:0]]) begin
            acc_nx_s = sqx_s;
        end else begin
            acc_nx_s = sq_s;
        end
    end

    // Next-state decode for the IDLE/RUN/DONE handshake sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bits_done_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            acc_r       <= ONE;
            x_q_r       <= {N{1'b0}};
            e_q_r       <= {N{1'b0}};
            k_r         <= K_INIT;
            out_y_r     <= {N{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q_r <= in_x;
                        e_q_r <= in_e;
                        acc_r <= ONE;
                        k_r   <= K_INIT;
                    end
                end
                ST_RUN: begin
                    if (bits_done_s) begin
                        out_y_r <= acc_r;
                    end else begin
                        acc_r <= acc_nx_s;
                        k_r   <= k_r - K_ONE;
                    end
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= ONE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_y     = out_y_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_gf_pow_engine.sv
// Scoreboard bench for gf_pow_engine (N=6, POLY=x^6+x+1).
module tb_gf_pow_engine;

    localparam int N = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_x = 6'd0;
    logic [5:0] in_e = 6'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [5:0] out_y;
    logic       busy;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         acc_t;
    int         vcnt;
    logic       prev_valid = 1'b0;
    logic [5:0] exp_q[$];
    int         accept_q[$];

    gf_pow_engine #(.N(6), .POLY(7'h43)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_e      (in_e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference multiply by shift-and-add with xtime reduction.
    function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p;
        logic [5:0] t;
        p = 6'h00;
        t = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ t;
            t = t[5] ? ((t << 1) ^ 6'h03) : (t << 1);
        end
        return p;
    endfunction

    // Reference power by repeated multiplication.
    function automatic logic [5:0] ref_pow(input logic [5:0] x, input logic [5:0] e);
        logic [5:0] r;
        r = 6'h01;
        for (int i = 0; i < int'(e); i++) r = gmul(r, x);
        return r;
    endfunction

    // Monitor: records acceptances, checks latency and pops the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            accept_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) accept_q.push_back(cyc + 1);
            if (out_valid && !prev_valid) begin
                if (accept_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
                else begin
                    acc_t = accept_q.pop_front();
                    chk("latency", cyc - acc_t, N + 1);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
                else chk("result", {26'd0, out_y}, {26'd0, exp_q.pop_front()});
            end
            prev_valid = out_valid;
        end
    end

    // Present one operand (caller is just after a rising edge); returns
    // just after the edge that accepted it.
    task automatic send(input logic [5:0] x, input logic [5:0] e, input logic [5:0] y);
        int w;
        in_valid = 1'b1;
        in_x = x;
        in_e = e;
        exp_q.push_back(y);
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 100) chk("accept_timeout", w, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait until every expected result has been seen.
    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed values.
        send(6'h02, 6'd6, 6'h03);
        drain();
        send(6'h02, 6'd62, 6'h21);
        send(6'h00, 6'd62, 6'h00);
        drain();
        send(6'h00, 6'd0, 6'h01);
        send(6'h2D, 6'd63, 6'h01);
        send(6'h01, 6'd38, 6'h01);
        drain();

        // Back-pressure: hold DONE for 5 cycles, then retire and accept again.
        out_ready = 1'b0;
        send(6'h02, 6'd62, 6'h21);
        vcnt = 0;
        while (out_valid !== 1'b1 && vcnt < 20) begin
            @(posedge clk); #1;
            vcnt++;
        end
        chk("done_wait", (vcnt < 20) ? 1 : 0, 1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_y", out_y, 6'h21);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_x = 6'h02;
        in_e = 6'd6;
        exp_q.push_back(6'h03);
        @(negedge clk);
        chk("retire_in_ready", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset on the third RUN cycle aborts the operation.
        send(6'h05, 6'd9, ref_pow(6'h05, 6'd9));
        @(negedge clk);
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_y", out_y, 0);
        vcnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) vcnt++;
        end
        chk("abort_no_valid", vcnt, 0);
        send(6'h02, 6'd6, 6'h03);
        drain();

        // Exhaustive sweep against the reference model.
        for (int x = 0; x < 64; x++) begin
            for (int e = 0; e < 64; e++) begin
                send(6'(x), 6'(e), ref_pow(6'(x), 6'(e)));
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
